// File: rtl/pixel_packer.sv
// pixel_packer
//   Packs a stream of 8-bit pixels into 32-bit little-endian words (the first
//   pixel of a group lands in [7:0]) and queues them in a DEPTH-word FIFO. The
//   word that closes a frame of FRAME_PIXELS pixels is tagged with word_last,
//   and frame_done pulses for one cycle after that frame's final pixel.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rstn         asynchronous active-low reset
//   clr          synchronous soft clear (overrides accept and pop)
//   pixel_in     8-bit pixel from the upstream stage
//   valid_in     pixel_in is valid
//   ready_in     block can accept a pixel (depends on registered state only)
//   word_out     packed word at the FIFO head (0 while the FIFO is empty)
//   word_last    head word closes a frame
//   word_valid   FIFO not empty
//   word_ready   consumer accepts the head word
//   fifo_level   number of words stored, 0..DEPTH
//   frame_done   one-cycle pulse after the last pixel of a frame is accepted
module pixel_packer #(
    parameter int DEPTH        = 8,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic [7:0]               pixel_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic [31:0]              word_out,
    output logic                     word_last,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     frame_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    localparam logic [1:0]       LANE_TOP = 2'd3;
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [1:0]       pack_q,  pack_d;
    logic [23:0]      hold_q,  hold_d;
    logic [PIX_W-1:0] pix_q,   pix_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             frame_done_q, frame_done_d;

    // Bit 32 of each entry is the end-of-frame tag.
    logic [32:0] mem_q [DEPTH];

    logic        accept;
    logic        push;
    logic        pop;
    logic [32:0] wr_word;
    logic [32:0] head;

    // Stalling only with a word ready to complete and no room for it keeps
    // ready_in free of any combinational path from word_ready.
    assign ready_in   = !((pack_q == LANE_TOP) && (level_q == LVL_FULL));
    assign word_valid = (level_q != '0);
    assign accept     = valid_in && ready_in;
    assign push       = accept && (pack_q == LANE_TOP);
    assign pop        = word_valid && word_ready;

    // Pixel FRAME_PIXELS-1 always lands in lane 3, so the tag can be taken
    // from the pixel counter at the moment the word is written.
    assign wr_word = {(pix_q == PIX_LAST), pixel_in, hold_q};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
        pack_d       = pack_q;
        hold_d       = hold_q;
        pix_d        = pix_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        frame_done_d = 1'b0;

        if (clr) begin
            pack_d   = '0;
            hold_d   = '0;
            pix_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (accept) begin
                case (pack_q)
                    2'd0:    hold_d[7:0]   = pixel_in;
                    2'd1:    hold_d[15:8]  = pixel_in;
                    2'd2:    hold_d[23:16] = pixel_in;
                    default: ;
                endcase
                pack_d       = pack_q + 2'd1;
                pix_d        = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
                frame_done_d = (pix_q == PIX_LAST);
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_q       <= '0;
            hold_q       <= '0;
            pix_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pack_q       <= pack_d;
            hold_q       <= hold_d;
            pix_q        <= pix_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observed once fifo_level says they hold data.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= wr_word;
    end

    // Gating with word_valid makes the outputs read zero while empty,
    // including immediately on reset, without resetting the array.
    assign head       = mem_q[rd_ptr_q];
    assign word_out   = word_valid ? head[31:0] : 32'h0;
    assign word_last  = word_valid && head[32];
    assign fifo_level = level_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer
//   Scenario tasks drive pixels and the consumer handshake. A reference
//   packing model pushes each expected {last, word} into a scoreboard queue as
//   the fourth pixel of a group is accepted; a negedge monitor pops and
//   compares whenever the DUT hands a word over.
module tb_pixel_packer;

    localparam int DEPTH = 8;
    localparam int FRAME = 1024;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             clr;
    logic [7:0]       pixel_in;
    logic             valid_in;
    logic             ready_in;
    logic [31:0]      word_out;
    logic             word_last;
    logic             word_valid;
    logic             word_ready;
    logic [LVL_W-1:0] fifo_level;
    logic             frame_done;

    pixel_packer #(.DEPTH(DEPTH), .FRAME_PIXELS(FRAME)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .pixel_in   (pixel_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .word_out   (word_out),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fifo_level (fifo_level),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          fails     = 0;
    int          fd_cnt    = 0;
    int          last_cnt  = 0;
    logic [31:0] last_word_seen = '0;

    logic [32:0] sb[$];
    int          m_pix  = 0;
    logic [31:0] m_hold = '0;

    // Scoreboard consumer: inputs change at posedge+1, so at negedge the
    // handshake that the next rising edge will act on is already settled.
    always @(negedge clk) begin
        if (rstn && !clr) begin
            if (frame_done) fd_cnt++;
            if (word_valid && word_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL pop_unexpected: got last=%0b word=%08h, expected no word", word_last, word_out);
                end else begin
                    logic [32:0] exp;
                    exp = sb.pop_front();
                    if ({word_last, word_out} !== exp) begin
                        fails++;
                        $display("FAIL word_compare: got last=%0b word=%08h, expected last=%0b word=%08h",
                                 word_last, word_out, exp[32], exp[31:0]);
                    end
                end
                if (word_last) begin
                    last_cnt++;
                    last_word_seen = word_out;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_accept(input logic [7:0] p);
        int   lane;
        logic last_b;
        lane = m_pix % 4;
        m_hold[lane*8 +: 8] = p;
        last_b = (m_pix == FRAME - 1);
        if (lane == 3) sb.push_back({last_b, m_hold});
        m_pix = (m_pix + 1) % FRAME;
    endtask

    task automatic model_clear();
        sb.delete();
        m_pix  = 0;
        m_hold = '0;
    endtask

    // Presents one pixel and returns at posedge+1 of the accepting edge.
    task automatic send_pixel(input logic [7:0] p);
        int waited;
        bit acc;
        waited   = 0;
        acc      = 1'b0;
        pixel_in = p;
        valid_in = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = ready_in;
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    tests_run++;
                    fails++;
                    $display("FAIL send_timeout: pixel %02h not accepted, ready_in=%0b expected 1", p, ready_in);
                    break;
                end
            end
        end
        if (acc) model_accept(p);
        valid_in = 1'b0;
    endtask

    task automatic apply_reset();
        rstn       = 1'b0;
        clr        = 1'b0;
        valid_in   = 1'b0;
        word_ready = 1'b0;
        pixel_in   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn     = 1'b1;
        fd_cnt   = 0;
        last_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        word_ready = 1'b1;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        word_ready = 1'b0;
        tests_run++;
        if (sb.size() != 0 || fifo_level !== '0 || word_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_drain: got pending=%0d level=%0d valid=%0b, expected 0 0 0",
                     name, sb.size(), fifo_level, word_valid);
        end
    endtask

    task automatic test_reset();
        rstn       = 1'b0;
        clr        = 1'b0;
        valid_in   = 1'b0;
        word_ready = 1'b0;
        pixel_in   = '0;
        #1;
        tests_run++;
        if ({ready_in, word_valid, word_last, frame_done, fifo_level, word_out} !==
            {1'b1, 1'b0, 1'b0, 1'b0, {LVL_W{1'b0}}, 32'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b last=%0b fd=%0b lvl=%0d word=%08h, expected 1 0 0 0 0 00000000",
                     ready_in, word_valid, word_last, frame_done, fifo_level, word_out);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        word_ready = 1'b1;
        send_pixel(8'h11);
        send_pixel(8'h22);
        send_pixel(8'h33);
        send_pixel(8'h44);
        tests_run++;
        if ({word_valid, word_last, word_out} !== {1'b1, 1'b0, 32'h44332211}) begin
            fails++;
            $display("FAIL basic_word: got vld=%0b last=%0b word=%08h, expected 1 0 44332211",
                     word_valid, word_last, word_out);
        end
        drain("basic");
    endtask

    task automatic test_full();
        apply_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH + 3; i++) send_pixel(8'(i + 8'h80));
        tests_run++;
        if (fifo_level !== LVL_W'(DEPTH) || ready_in !== 1'b0) begin
            fails++;
            $display("FAIL full_stall: got lvl=%0d rdy=%0b, expected %0d 0", fifo_level, ready_in, DEPTH);
        end
        pixel_in = 8'hA5;
        valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        valid_in = 1'b0;
        tests_run++;
        if (fifo_level !== LVL_W'(DEPTH) || ready_in !== 1'b0) begin
            fails++;
            $display("FAIL full_hold: got lvl=%0d rdy=%0b, expected %0d 0", fifo_level, ready_in, DEPTH);
        end
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        tests_run++;
        if (ready_in !== 1'b1 || fifo_level !== LVL_W'(DEPTH - 1)) begin
            fails++;
            $display("FAIL full_release: got rdy=%0b lvl=%0d, expected 1 %0d", ready_in, fifo_level, DEPTH - 1);
        end
        send_pixel(8'hA5);
        tests_run++;
        if (fifo_level !== LVL_W'(DEPTH)) begin
            fails++;
            $display("FAIL full_refill: got lvl=%0d, expected %0d", fifo_level, DEPTH);
        end
        drain("full");
    endtask

    task automatic test_frame();
        apply_reset();
        word_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) send_pixel(8'(i));
        tests_run++;
        if (frame_done !== 1'b1) begin
            fails++;
            $display("FAIL frame_done_pulse: got %0b, expected 1", frame_done);
        end
        drain("frame1");
        tests_run++;
        if (fd_cnt != 1 || last_cnt != 1 || last_word_seen !== 32'hFFFEFDFC) begin
            fails++;
            $display("FAIL frame1_end: got fd=%0d last=%0d word=%08h, expected 1 1 fffefdfc",
                     fd_cnt, last_cnt, last_word_seen);
        end
        word_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) send_pixel(8'(i * 7 + 3));
        drain("frame2");
        tests_run++;
        if (fd_cnt != 2 || last_cnt != 2) begin
            fails++;
            $display("FAIL frame2_end: got fd=%0d last=%0d, expected 2 2", fd_cnt, last_cnt);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 12; i++) send_pixel(8'(8'h30 + i));
        tests_run++;
        if (fifo_level !== LVL_W'(3)) begin
            fails++;
            $display("FAIL b2b_prefill: got lvl=%0d, expected 3", fifo_level);
        end
        for (int i = 0; i < 3; i++) send_pixel(8'(8'h50 + i));
        word_ready = 1'b1;
        send_pixel(8'h53);
        word_ready = 1'b0;
        tests_run++;
        if (fifo_level !== LVL_W'(3)) begin
            fails++;
            $display("FAIL b2b_level: got lvl=%0d, expected 3", fifo_level);
        end
        drain("b2b");
    endtask

    task automatic test_clear();
        apply_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 22; i++) send_pixel(8'(8'hC0 + i));
        tests_run++;
        if (fifo_level !== LVL_W'(5)) begin
            fails++;
            $display("FAIL clr_prefill: got lvl=%0d, expected 5", fifo_level);
        end
        clr        = 1'b1;
        pixel_in   = 8'hEE;
        valid_in   = 1'b1;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        clr        = 1'b0;
        valid_in   = 1'b0;
        word_ready = 1'b0;
        model_clear();
        tests_run++;
        if (fifo_level !== '0 || word_valid !== 1'b0) begin
            fails++;
            $display("FAIL clr_empty: got lvl=%0d vld=%0b, expected 0 0", fifo_level, word_valid);
        end
        send_pixel(8'h01);
        send_pixel(8'h02);
        send_pixel(8'h03);
        send_pixel(8'h04);
        tests_run++;
        if ({word_valid, word_last, word_out, fifo_level} !== {1'b1, 1'b0, 32'h04030201, LVL_W'(1)}) begin
            fails++;
            $display("FAIL clr_word0: got vld=%0b last=%0b word=%08h lvl=%0d, expected 1 0 04030201 1",
                     word_valid, word_last, word_out, fifo_level);
        end
        drain("clr");
    endtask

    task automatic test_async_reset();
        apply_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_pixel(8'(8'hD0 + i));
        tests_run++;
        if (fifo_level !== LVL_W'(1) || word_valid !== 1'b1) begin
            fails++;
            $display("FAIL arst_prefill: got lvl=%0d vld=%0b, expected 1 1", fifo_level, word_valid);
        end
        #3;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({ready_in, word_valid, word_last, frame_done, fifo_level, word_out} !==
            {1'b1, 1'b0, 1'b0, 1'b0, {LVL_W{1'b0}}, 32'h0}) begin
            fails++;
            $display("FAIL arst_outputs: got rdy=%0b vld=%0b last=%0b fd=%0b lvl=%0d word=%08h, expected 1 0 0 0 0 00000000",
                     ready_in, word_valid, word_last, frame_done, fifo_level, word_out);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_pixel(8'h10);
        send_pixel(8'h20);
        send_pixel(8'h30);
        send_pixel(8'h40);
        tests_run++;
        if ({word_valid, word_last, word_out, fifo_level} !== {1'b1, 1'b0, 32'h40302010, LVL_W'(1)}) begin
            fails++;
            $display("FAIL arst_word0: got vld=%0b last=%0b word=%08h lvl=%0d, expected 1 0 40302010 1",
                     word_valid, word_last, word_out, fifo_level);
        end
        drain("arst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_frame();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/pixel_packer.md
PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
- REQ-001: Parameter DEPTH, default 8: FIFO depth in 32-bit words; power of two, at least 2.
- REQ-002: Parameter FRAME_PIXELS, default 1024: pixels per frame (32x32); multiple of 4.
- REQ-003: Port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-004: Port rstn, input, 1 bit: reset; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
- REQ-005: Port clr, input, 1 bit: synchronous soft clear.
- REQ-006: Port pixel_in, input, 8 bits: pixel from the upstream processing stage.
- REQ-007: Port valid_in, input, 1 bit: pixel_in is valid.
- REQ-008: Port ready_in, output, 1 bit: block can accept a pixel.
- REQ-009: Port word_out, output, 32 bits: packed word at the FIFO head.
- REQ-010: Port word_last, output, 1 bit: head word is the last word of a frame.
- REQ-011: Port word_valid, output, 1 bit: FIFO is not empty.
- REQ-012: Port word_ready, input, 1 bit: consumer accepts the head word.
- REQ-013: Port fifo_level, output, $clog2(DEPTH)+1 bits: words currently stored.
- REQ-014: Port frame_done, output, 1 bit: one-cycle end-of-frame pulse.

Function
- REQ-015: A pixel SHALL be accepted when valid_in && ready_in on a rising edge.
- REQ-016: A word SHALL be popped when word_valid && word_ready on a rising edge.
- REQ-017: The 2-bit pack counter SHALL index the byte lane: lane 0 -> [7:0], 1 -> [15:8], 2 -> [23:16], 3 -> [31:24]. The first pixel of a group goes in [7:0].
- REQ-018: Lanes 0-2 SHALL go into a holding register. On acceptance in lane 3, the assembled word SHALL be written to the FIFO tail in the same edge, and the pack counter SHALL wrap to 0.
- REQ-019: ready_in SHALL be low only when pack counter == 3 and fifo_level == DEPTH.
  - ready_in SHALL be registered-state-only, with no combinational path from word_ready.
- REQ-020: A word SHALL appear on word_out/word_valid the cycle after its write edge. There is no empty-FIFO bypass; minimum latency from 4th pixel acceptance to word_valid is 1 cycle.
- REQ-021: word_out and word_last SHALL hold stable while word_valid && !word_ready.
- REQ-022: A 0..FRAME_PIXELS-1 pixel counter SHALL advance on each acceptance and wrap to 0 after FRAME_PIXELS-1.
- REQ-023: The word written with pixel FRAME_PIXELS-1 SHALL carry word_last=1 (stored as FIFO bit 32). All other words SHALL carry word_last=0.
- REQ-024: frame_done SHALL be high for exactly the one cycle after the edge accepting pixel FRAME_PIXELS-1.
- REQ-025: Simultaneous push and pop SHALL leave fifo_level unchanged; both operations take effect.
- REQ-026: Pop from an empty FIFO SHALL be impossible, because word_valid is low. word_ready while empty SHALL have no effect.
- REQ-027: Read and write pointers SHALL wrap modulo DEPTH. Full and empty SHALL be distinguished by fifo_level.
- REQ-028: clr=1 SHALL, on that edge, empty the FIFO, zero the pack counter, pixel counter and holding register, and force frame_done=0.
  - clr SHALL override any simultaneous accept or pop; the pixel presented that cycle is discarded.

Reset
- REQ-029: rstn low SHALL immediately force: ready_in=1, word_valid=0, word_out=0, word_last=0, fifo_level=0, frame_done=0, all counters and pointers 0.
- REQ-030: Reset asserted mid-frame SHALL discard partial words and FIFO contents. The next accepted pixel after release SHALL be pixel 0, lane 0.

Verification
- REQ-031: Pixels 0x11,0x22,0x33,0x44 with word_ready=1 -> one cycle later word_out=0x44332211, word_valid=1, word_last=0.
- REQ-032: word_ready=0, stream 4*DEPTH+3 pixels -> fifo_level=8 and ready_in=0 while pack counter==3.
  - Then one pop -> ready_in=1 next cycle; no pixel lost or duplicated.
- REQ-033: Full 1024-pixel frame of values (i mod 256) -> 256 words in order, only word 255 has word_last=1 (0xFFFEFDFC), frame_done pulses once; the second frame restarts cleanly.
- REQ-034: FIFO holding 3 words, push and pop on the same edge -> fifo_level stays 3 and ordering is preserved.
- REQ-035: clr asserted after 2 pixels of a group with 5 words stored -> next cycle fifo_level=0, word_valid=0.
  - The next 4 pixels form word 0 with word_last=0.
- REQ-036: rstn pulsed low asynchronously mid-frame -> outputs take reset values before the next clk edge; behaviour after release is per REQ-030.
